// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types, widths and reset defaults for the pipelined decision tree
package dtc_pkg;

   // Upper bounds on the feature vector and path register carried through each stage
   localparam int FEAT_MAX = 32;
   localparam int PATH_MAX = 8;

   // Leaf j resets to label (j & DEF_LABEL_MASK)
   localparam int DEF_LABEL_MASK = 1;

   typedef struct packed {
      logic                valid;
      logic [FEAT_MAX-1:0] feat;
      logic [PATH_MAX-1:0] path;
   } stage_t;

   // Width of cfg_data: wide enough for a feature select and for a class label
   function automatic int sel_w(input int n_feat, input int cls_w);
      int c;
      c = $clog2(n_feat);
      return (c > cls_w) ? c : cls_w;
   endfunction

   function automatic int def_label(input int j);
      return j & DEF_LABEL_MASK;
   endfunction

endpackage

// File: rtl/dtc_level.sv
// dtc_level: evaluates one tree level, appending the node decision to the path
module dtc_level
   import dtc_pkg::*;
#(
   parameter int N_FEAT = 10,
   parameter int LEVEL  = 0,
   parameter int FW     = 4
) (
   input  stage_t                      cur,
   input  logic [(2**LEVEL)*FW-1:0]    sels,
   output stage_t                      nxt
);

   localparam int FIW = $clog2(FEAT_MAX);

   int            idx;
   logic [FW-1:0] sel;
   logic          b;

   // The path so far is the node's offset within this level; out-of-range selects test 0
   always_comb begin
      idx      = int'(cur.path) & ((1 << LEVEL) - 1);
      sel      = sels[idx*FW +: FW];
      b        = (int'(sel) < N_FEAT) ? cur.feat[FIW'(sel)] : 1'b0;
      nxt      = cur;
      nxt.path = (cur.path << 1) | PATH_MAX'(b);
   end

endmodule

// File: rtl/dtc_pipe.sv
// dtc_pipe: DEPTH-stage pipelined binary decision tree classifier with writable tables
// Optional macro DTC_PIPE_STATS_EN adds stat_cnt, a saturating count of nonzero results.
module dtc_pipe
   import dtc_pkg::*;
#(
   parameter int  N_FEAT = 10,
   parameter int  DEPTH  = 3,
   parameter int  CLS_W  = 1,
   localparam int FW     = sel_w(N_FEAT, CLS_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_FEAT-1:0] inp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CLS_W-1:0]  outp,
   input  logic              cfg_we,
   output logic              cfg_ready,
   input  logic              cfg_leaf,
   input  logic [DEPTH-1:0]  cfg_addr,
   input  logic [FW-1:0]     cfg_data
`ifdef DTC_PIPE_STATS_EN
   ,
   output logic [15:0]       stat_cnt
`endif
);

   localparam int NN = 2**DEPTH - 1;
   localparam int NL = 2**DEPTH;

   logic [FW-1:0]    feat_tbl [NN];
   logic [CLS_W-1:0] leaf_tbl [NL];
   stage_t           st [DEPTH];
   stage_t           nx [DEPTH];
   stage_t           in_st;
   logic             adv, wr, unused_bits;

   assign adv         = !st[DEPTH-1].valid | out_ready;
   assign wr          = cfg_we & cfg_ready;
   assign in_ready    = adv & !rst & !wr;
   assign in_st       = '{valid: in_valid & in_ready, feat: FEAT_MAX'(inp), path: '0};
   assign out_valid   = st[DEPTH-1].valid;
   assign outp        = out_valid ? leaf_tbl[st[DEPTH-1].path[DEPTH-1:0]] : '0;
   assign unused_bits = ^{st[DEPTH-1].feat, st[DEPTH-1].path};

   // Tables may only change while nothing is in flight or being offered
   always_comb begin
      cfg_ready = !in_valid;
      for (int k = 0; k < DEPTH; k++)
         if (st[k].valid) cfg_ready = 1'b0;
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
      logic [(2**k)*FW-1:0] sels;
      // Gather the feature selects of the 2^k nodes on this level
      always_comb begin
         for (int j = 0; j < 2**k; j++)
            sels[j*FW +: FW] = feat_tbl[2**k - 1 + j];
      end
      if (k == 0) begin : g_first
         dtc_level #(.N_FEAT(N_FEAT), .LEVEL(k), .FW(FW)) u_level (
            .cur  (in_st),
            .sels (sels),
            .nxt  (nx[k])
         );
      end else begin : g_rest
         dtc_level #(.N_FEAT(N_FEAT), .LEVEL(k), .FW(FW)) u_level (
            .cur  (st[k-1]),
            .sels (sels),
            .nxt  (nx[k])
         );
      end
   end

   // All stages shift together, or all hold while the output is stalled
   always_ff @(posedge clk) begin
      if (rst)
         for (int k = 0; k < DEPTH; k++) st[k] <= '0;
      else if (adv)
         for (int k = 0; k < DEPTH; k++) st[k] <= nx[k];
   end

   // Table writes land only when the pipeline is empty; out-of-range node writes drop
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NN; i++) feat_tbl[i] <= '0;
         for (int j = 0; j < NL; j++) leaf_tbl[j] <= CLS_W'(def_label(j));
      end else if (wr) begin
         if (cfg_leaf)
            leaf_tbl[cfg_addr] <= cfg_data[CLS_W-1:0];
         else if (int'(cfg_addr) < NN)
            feat_tbl[cfg_addr] <= cfg_data;
      end
   end

`ifdef DTC_PIPE_STATS_EN
   // Count accepted results with a nonzero label, saturating
   always_ff @(posedge clk) begin
      if (rst)
         stat_cnt <= '0;
      else if (out_valid && out_ready && outp != '0 && stat_cnt != 16'hFFFF)
         stat_cnt <= stat_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dtc_pipe.sv
// tb_dtc_pipe: directed self-checking bench for dtc_pipe (DEPTH=3, N_FEAT=10, CLS_W=1)
module tb_dtc_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       cfg_we = 1'b0;
   logic       cfg_leaf = 1'b0;
   logic [9:0] inp = '0;
   logic [2:0] cfg_addr = '0;
   logic [3:0] cfg_data = '0;
   logic       in_ready, out_valid, cfg_ready;
   logic [0:0] outp;
`ifdef DTC_PIPE_STATS_EN
   logic [15:0] stat_cnt;
`endif

   int checks = 0;
   int failures = 0;

   dtc_pipe #(.N_FEAT(10), .DEPTH(3), .CLS_W(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp       (inp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outp      (outp),
      .cfg_we    (cfg_we),
      .cfg_ready (cfg_ready),
      .cfg_leaf  (cfg_leaf),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data)
`ifdef DTC_PIPE_STATS_EN
      ,
      .stat_cnt  (stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic leaf, input logic [2:0] addr, input logic [3:0] data);
      cfg_we = 1'b1;
      cfg_leaf = leaf;
      cfg_addr = addr;
      cfg_data = data;
      tick();
      cfg_we = 1'b0;
   endtask

   // Send one sample with no backpressure and check the label it produces
   task automatic send_wait(input logic [9:0] v, input logic e, input string name);
      int n;
      in_valid = 1'b1;
      inp = v;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s: no out_valid within budget", name);
      end else if (outp !== e) begin
         failures++;
         $display("FAIL %s: outp=%0h expected %0h", name, outp, e);
      end
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || outp !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: out_valid=%0b outp=%0h expected 0 0", out_valid, outp);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready: in_ready=%0b expected 0", in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_ready: in_ready=%0b cfg_ready=%0b expected 1 1", in_ready, cfg_ready);
      end
   endtask

   // Reset tables test bit 0 at every node, and leaf j holds j[0]
   task automatic test_default_table;
      send_wait(10'h001, 1'b1, "default_a");
      send_wait(10'h3FE, 1'b0, "default_b");
      send_wait(10'h3FF, 1'b1, "default_c");
   endtask

   task automatic program_table;
      int         fv [7] = '{5, 7, 4, 0, 9, 8, 8};
      logic [7:0] lv;
      lv = 8'b0101_1110;
      for (int i = 0; i < 7; i++) cfg_write(1'b0, 3'(i), 4'(fv[i]));
      for (int j = 0; j < 8; j++) cfg_write(1'b1, 3'(j), {3'b000, lv[j]});
   endtask

   task automatic test_latency;
      in_valid = 1'b1;
      inp = 10'h020;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL lat_accept: in_ready=%0b expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (out_valid !== (k == 3)) begin
            failures++;
            $display("FAIL lat_cycle%0d: out_valid=%0b expected %0b", k, out_valid, (k == 3));
         end
         if (k < 3) tick();
      end
      checks++;
      if (outp !== 1'b1) begin
         failures++;
         $display("FAIL lat_label: outp=%0h expected 1", outp);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat_drop: out_valid=%0b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] bv [8] = '{10'h000, 10'h001, 10'h080, 10'h020, 10'h120, 10'h030, 10'h130, 10'h3FF};
      logic       be [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 8);
         if (c < 8) inp = bv[c];
         #1;
         if (c < 8) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_ready%0d: in_ready=%0b expected 1", c, in_ready);
            end
         end
         tick();
         checks++;
         if (c >= 2 && c < 10) begin
            if (out_valid !== 1'b1 || outp !== be[c-2]) begin
               failures++;
               $display("FAIL b2b_out%0d: out_valid=%0b outp=%0h expected 1 %0h", c - 2, out_valid, outp, be[c-2]);
            end
         end else if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle%0d: out_valid=%0b expected 0", c, out_valid);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [9:0] pv [4] = '{10'h001, 10'h000, 10'h080, 10'h120};
      logic       pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int         idx = 0;
      int         got = 0;
      logic       acc, xfer, ov;
      for (int c = 0; c < 20; c++) begin
         in_valid = (idx < 4);
         inp = pv[(idx < 4) ? idx : 0];
         out_ready = (c >= 8);
         #1;
         if (c >= 3 && c < 8) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || outp !== 1'b1) begin
               failures++;
               $display("FAIL bp_hold%0d: in_ready=%0b out_valid=%0b outp=%0h expected 0 1 1", c, in_ready, out_valid, outp);
            end
         end
         acc = in_valid & in_ready;
         xfer = out_valid & out_ready;
         ov = outp;
         tick();
         if (acc) idx++;
         if (xfer) begin
            checks++;
            if (got >= 4 || ov !== pe[got]) begin
               failures++;
               $display("FAIL bp_out%0d: outp=%0h expected %0h", got, ov, (got < 4) ? pe[got] : 1'bx);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 4 || idx != 4) begin
         failures++;
         $display("FAIL bp_count: results=%0d accepted=%0d expected 4 4", got, idx);
      end
   endtask

   task automatic test_cfg_inflight;
      int n;
      out_ready = 1'b1;
      in_valid = 1'b1;
      inp = 10'h020;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL cfg_block_in: cfg_ready=%0b expected 0", cfg_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL cfg_block_flight: cfg_ready=%0b expected 0", cfg_ready);
      end
      cfg_write(1'b1, 3'd4, 4'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1 || outp !== 1'b1) begin
         failures++;
         $display("FAIL cfg_ignored: out_valid=%0b outp=%0h expected 1 1", out_valid, outp);
      end
      tick();
      checks++;
      if (cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL cfg_drained: cfg_ready=%0b expected 1", cfg_ready);
      end
      cfg_write(1'b1, 3'd4, 4'd0);
      send_wait(10'h020, 1'b0, "cfg_applied");
   endtask

   task automatic test_rst_midflight;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         inp = 10'h030;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmf_full: out_valid=%0b expected 1", out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_valid !== 1'b0 || outp !== 1'b0) begin
            failures++;
            $display("FAIL rstmf_quiet%0d: out_valid=%0b outp=%0h expected 0 0", i, out_valid, outp);
         end
         tick();
      end
      send_wait(10'h030, 1'b0, "rstmf_tbl_a");
      send_wait(10'h121, 1'b1, "rstmf_tbl_b");
   endtask

`ifdef DTC_PIPE_STATS_EN
   task automatic test_stats;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (stat_cnt !== 16'd0) begin
         failures++;
         $display("FAIL stats_reset: stat_cnt=%0d expected 0", stat_cnt);
      end
      send_wait(10'h001, 1'b1, "stats_a");
      send_wait(10'h000, 1'b0, "stats_b");
      send_wait(10'h001, 1'b1, "stats_c");
      send_wait(10'h001, 1'b1, "stats_d");
      checks++;
      if (stat_cnt !== 16'd3) begin
         failures++;
         $display("FAIL stats_count: stat_cnt=%0d expected 3", stat_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_default_table();
      program_table();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_cfg_inflight();
      test_rst_midflight();
`ifdef DTC_PIPE_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
